// File: rtl/cam_frame_capture.sv
// -----------------------------------------------------------------------------
// cam_frame_capture
//
// Captures frames from a parallel 8-bit camera (PCLK/VS/HS/DATA) running in an
// unrelated clock domain. All camera signals are resynchronised into i_clk and
// PCLK is treated as data (edge-detected), so no logic runs on the camera clock.
// Two consecutive bytes form one 16-bit sensor pixel (high byte first). The
// pixel is converted to RGB565, decimated by DECIM in both axes and presented
// with its output coordinates on a one-cycle o_valid strobe.
//
// Optional feature (macro CAM_CAPTURE_LINE_CHECK_EN): count bytes per line and
// raise a sticky o_line_err when a line does not carry exactly 2*H_ACTIVE
// bytes. Without the macro o_line_err is tied low.
//
// Ports
//   i_clk, i_n_reset      system clock (>= 4x PCLK), async active-low reset
//   i_start               arm a capture (honoured only in IDLE)
//   i_continuous          re-arm automatically after each frame
//   i_PCLK, i_VS, i_HS    camera timing, asynchronous to i_clk
//   i_DATA                camera byte
//   o_pixel_data          captured pixel, always RGB565
//   o_h_addr, o_v_addr    output pixel coordinates (sensor position / DECIM)
//   o_valid               one-cycle strobe qualifying data and addresses
//   o_frame_done          one-cycle pulse at the end of a captured frame
//   o_busy                state is not IDLE
//   o_state               one-hot state vector
//   o_line_err            sticky line-length error
// -----------------------------------------------------------------------------
module cam_frame_capture #(
    parameter  int DATA_WIDTH = 8,
    parameter  int H_ACTIVE   = 640,
    parameter  int V_ACTIVE   = 480,
    parameter  int DECIM      = 2,    // 1, 2 or 4
    parameter  int PXL_FMT    = 0,    // 0 = RGB565, 1 = RGB555, 2 = RGB444
    localparam int OH         = H_ACTIVE / DECIM,
    localparam int OV         = V_ACTIVE / DECIM
) (
    input  logic                      i_clk,
    input  logic                      i_n_reset,
    input  logic                      i_start,
    input  logic                      i_continuous,
    input  logic                      i_PCLK,
    input  logic                      i_VS,
    input  logic                      i_HS,
    input  logic [DATA_WIDTH-1:0]     i_DATA,
    output logic [15:0]               o_pixel_data,
    output logic [$clog2(OH):0]       o_h_addr,
    output logic [$clog2(OV):0]       o_v_addr,
    output logic                      o_valid,
    output logic                      o_frame_done,
    output logic                      o_busy,
    output logic [4:0]                o_state,
    output logic                      o_line_err
);

    localparam int HW = $clog2(OH) + 1;
    localparam int VW = $clog2(OV) + 1;
    // Sensor counters saturate at H_ACTIVE / V_ACTIVE so excess pixels and
    // lines can never wrap back into the kept window.
    localparam int CW = $clog2(H_ACTIVE + 1);
    localparam int LW = $clog2(V_ACTIVE + 1);
    localparam int SH = $clog2(DECIM);

    localparam logic [CW-1:0] H_LIM  = CW'(H_ACTIVE);
    localparam logic [LW-1:0] V_LIM  = LW'(V_ACTIVE);
    localparam logic [CW-1:0] C_MASK = CW'(DECIM - 1);
    localparam logic [LW-1:0] L_MASK = LW'(DECIM - 1);

    typedef enum logic [4:0] {
        IDLE         = 5'b00001,
        WAIT_VS_RISE = 5'b00010,
        WAIT_VS_FALL = 5'b00100,
        ACTIVE       = 5'b01000,
        FRAME_DONE   = 5'b10000
    } state_t;

    state_t state_q, state_d;

    // ---------------------------------------------------------------------
    // Synchronisers: control and data go through the same depth so the
    // byte seen in the PCLK-rise cycle is the one present at that PCLK edge.
    // Stage 3 of the control bits is the previous value for edge detection.
    // ---------------------------------------------------------------------
    logic [2:0]            ctl_s1_q, ctl_s2_q, ctl_s3_q;   // {pclk, vs, hs}
    logic [DATA_WIDTH-1:0] data_s1_q, data_s2_q;

    logic pclk_rise, vs_rise, vs_fall, hs_fall, hs_level;
    logic [7:0] cam_byte;

    assign pclk_rise = ctl_s2_q[2] & ~ctl_s3_q[2];
    assign vs_rise   = ctl_s2_q[1] & ~ctl_s3_q[1];
    assign vs_fall   = ~ctl_s2_q[1] & ctl_s3_q[1];
    assign hs_fall   = ~ctl_s2_q[0] & ctl_s3_q[0];
    assign hs_level  = ctl_s2_q[0];
    assign cam_byte  = 8'(data_s2_q);

    // Datapath state
    logic [CW-1:0] col_q, col_d;
    logic [LW-1:0] line_q, line_d;
    logic          phase_q, phase_d;      // 0: expecting high byte
    logic [7:0]    hi_q, hi_d;
    logic          valid_q, valid_d;
    logic [15:0]   pix_q, pix_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;

    logic start_frame, byte_stb, keep;

    assign start_frame = (state_q == WAIT_VS_FALL) && vs_fall;
    assign byte_stb    = (state_q == ACTIVE) && hs_level && pclk_rise && !hs_fall;
    assign keep        = (col_q < H_LIM) && (line_q < V_LIM)
                      && ((col_q & C_MASK) == '0) && ((line_q & L_MASK) == '0);

    function automatic logic [15:0] to_rgb565(input logic [15:0] w);
        logic [15:0] r;
        r = w;
        case (PXL_FMT)
            1:       r = {w[14:10], w[9:5], w[9], w[4:0]};
            2:       r = {w[11:8], w[11], w[7:4], w[7:6], w[3:0], w[3]};
            default: r = w;
        endcase
        return r;
    endfunction

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:         if (i_start) state_d = WAIT_VS_RISE;
            WAIT_VS_RISE: if (vs_rise) state_d = WAIT_VS_FALL;
            WAIT_VS_FALL: if (vs_fall) state_d = ACTIVE;
            ACTIVE:       if (vs_rise) state_d = FRAME_DONE;
            FRAME_DONE:   state_d = i_continuous ? WAIT_VS_FALL : IDLE;
            default:      state_d = IDLE;
        endcase
    end

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        col_d   = col_q;
        line_d  = line_q;
        phase_d = phase_q;
        hi_d    = hi_q;
        valid_d = 1'b0;
        pix_d   = pix_q;
        h_d     = h_q;
        v_d     = v_q;

        if (start_frame) begin
            col_d   = '0;
            line_d  = '0;
            phase_d = 1'b0;
        end else if (state_q == ACTIVE && hs_fall) begin
            // A dangling high byte is dropped by clearing the phase.
            phase_d = 1'b0;
            col_d   = '0;
            if (line_q != V_LIM) line_d = line_q + 1'b1;
        end else if (byte_stb) begin
            // Evaluated even when VS rises in the same cycle, so a pixel
            // completing alongside the frame end is still delivered.
            if (!phase_q) begin
                hi_d    = cam_byte;
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
                if (keep) begin
                    valid_d = 1'b1;
                    pix_d   = to_rgb565({hi_q, cam_byte});
                    h_d     = HW'(col_q >> SH);
                    v_d     = VW'(line_q >> SH);
                end
                if (col_q != H_LIM) col_d = col_q + 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples the values from before the clock edge.
    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            state_q   <= IDLE;
            ctl_s1_q  <= '0;
            ctl_s2_q  <= '0;
            ctl_s3_q  <= '0;
            data_s1_q <= '0;
            data_s2_q <= '0;
            col_q     <= '0;
            line_q    <= '0;
            phase_q   <= 1'b0;
            hi_q      <= '0;
            valid_q   <= 1'b0;
            pix_q     <= '0;
            h_q       <= '0;
            v_q       <= '0;
        end else begin
            state_q   <= state_d;
            ctl_s1_q  <= {i_PCLK, i_VS, i_HS};
            ctl_s2_q  <= ctl_s1_q;
            ctl_s3_q  <= ctl_s2_q;
            data_s1_q <= i_DATA;
            data_s2_q <= data_s1_q;
            col_q     <= col_d;
            line_q    <= line_d;
            phase_q   <= phase_d;
            hi_q      <= hi_d;
            valid_q   <= valid_d;
            pix_q     <= pix_d;
            h_q       <= h_d;
            v_q       <= v_d;
        end
    end

    // ---------------------------------------------------------------------
    // Optional line-length checker
    // ---------------------------------------------------------------------
`ifdef CAM_CAPTURE_LINE_CHECK_EN
    localparam int BW = $clog2(2 * H_ACTIVE + 2);
    localparam logic [BW-1:0] B_FULL = BW'(2 * H_ACTIVE);
    localparam logic [BW-1:0] B_SAT  = BW'(2 * H_ACTIVE + 1);

    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          lerr_q, lerr_d;

    always_comb begin
        bcnt_d = bcnt_q;
        lerr_d = lerr_q;
        if (start_frame) begin
            bcnt_d = '0;
            lerr_d = 1'b0;
        end else if (state_q == ACTIVE && hs_fall) begin
            bcnt_d = '0;
            if (bcnt_q != B_FULL) lerr_d = 1'b1;
        end else if (byte_stb && bcnt_q != B_SAT) begin
            bcnt_d = bcnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            bcnt_q <= '0;
            lerr_q <= 1'b0;
        end else begin
            bcnt_q <= bcnt_d;
            lerr_q <= lerr_d;
        end
    end

    assign o_line_err = lerr_q;
`else
    assign o_line_err = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign o_pixel_data = pix_q;
    assign o_h_addr     = h_q;
    assign o_v_addr     = v_q;
    assign o_valid      = valid_q;
    assign o_frame_done = (state_q == FRAME_DONE);
    assign o_busy       = (state_q != IDLE);
    assign o_state      = state_q;

endmodule
